// File: rtl/fetch_align.sv
// Fetch-packet aligner: slices one I-cache line from the fetch PC onward, cuts at the first
// predicted-taken control transfer, and buffers the packet in a 2-entry skid FIFO for the queue.
module fetch_align #(
    parameter int LINE_WORDS = 8,
    parameter int OUT_SLOTS  = 10,
    parameter int XLEN       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_lineValid,
    output logic                      o_lineReady,
    input  logic [XLEN-6:0]           i_lineAddr,
    input  logic [LINE_WORDS*32-1:0]  i_lineData,
    input  logic [XLEN-1:0]           i_startPC,
    output logic                      o_outValid,
    input  logic                      i_outReady,
    output logic [OUT_SLOTS*64-1:0]   o_alignedInstructionTable,
    output logic [3:0]                o_cutPosition,
    output logic                      o_bNum,
    output logic [XLEN-1:0]           o_jumpAddr,
    output logic                      o_refetch,
    output logic                      o_fault
);

    localparam int OFF_W = $clog2(LINE_WORDS);

    typedef struct packed {
        logic [OUT_SLOTS*64-1:0] slots;
        logic [3:0]              cut;
        logic                    bnum;
        logic [XLEN-1:0]         jump;
        logic                    fault;
    } pkt_t;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid may not depend on ready, and ready is registered (FIFO has room next cycle).
    logic [1:0]       count;
    logic [1:0]       count_after;
    logic [1:0]       count_nxt;
    logic             ready_q;
    logic             refetch_q;
    pkt_t             head_q;
    pkt_t             tail_q;
    pkt_t             pkt;
    logic             accept;
    logic             stale;
    logic             enq;
    logic             deq;
    logic             found;
    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  insn;
    logic [XLEN-1:0]  pc;
    int               idx;

    assign stale       = i_startPC[XLEN-1:5] != i_lineAddr;
    assign accept      = i_lineValid && ready_q && !i_flush;
    assign enq         = accept && !stale;
    assign deq         = o_outValid && i_outReady;
    assign count_after = count - {1'b0, deq};
    assign count_nxt   = count_after + {1'b0, enq};

    // Slot build and predecode; the first predicted-taken JAL or backward branch ends the packet.
    always_comb begin
        pkt   = '0;
        pkt.cut = 4'hF;
        found = 1'b0;
        insn  = '0;
        pc    = '0;
        idx   = 0;
        off   = i_startPC[OFF_W+1:2];
        base  = {i_lineAddr, 5'b0};
        if (i_startPC[1:0] != 2'b00) begin
            pkt.fault = 1'b1;
        end else begin
            pkt.cut = 4'(LINE_WORDS - 1) - 4'(off);
            for (int k = 0; k < OUT_SLOTS; k++) begin
                idx = k + int'(off);
                if (idx < LINE_WORDS) begin
                    insn = i_lineData[idx*32 +: 32];
                    pc   = base + XLEN'(4 * idx);
                    pkt.slots[k*64 +: 32]    = insn;
                    pkt.slots[k*64+32 +: 32] = pc;
                    if (!found && insn[6:0] == 7'b1101111) begin
                        found    = 1'b1;
                        pkt.cut  = 4'(k);
                        pkt.bnum = 1'b1;
                        pkt.jump = pc + {{(XLEN-21){insn[31]}}, insn[31], insn[19:12],
                                         insn[20], insn[30:21], 1'b0};
                    end else if (!found && insn[6:0] == 7'b1100011 && insn[31]) begin
                        found    = 1'b1;
                        pkt.cut  = 4'(k);
                        pkt.bnum = 1'b1;
                        pkt.jump = pc + {{(XLEN-13){insn[31]}}, insn[31], insn[7],
                                         insn[30:25], insn[11:8], 1'b0};
                    end
                end
            end
        end
    end

    // Shift-style FIFO: head_q always holds the oldest packet, tail_q the second.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            count     <= 2'd0;
            ready_q   <= 1'b1;
            refetch_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            count     <= count_nxt;
            ready_q   <= count_nxt < 2'd2;
            refetch_q <= accept && stale;
            if (deq && count == 2'd2) head_q <= tail_q;
            if (enq) begin
                if (count_after == 2'd0) head_q <= pkt;
                else                     tail_q <= pkt;
            end
        end
    end

    assign o_lineReady               = ready_q;
    assign o_refetch                 = refetch_q;
    assign o_outValid                = count != 2'd0;
    assign o_alignedInstructionTable = o_outValid ? head_q.slots : '0;
    assign o_cutPosition             = o_outValid ? head_q.cut   : 4'hF;
    assign o_bNum                    = o_outValid && head_q.bnum;
    assign o_jumpAddr                = o_outValid ? head_q.jump  : '0;
    assign o_fault                   = o_outValid && head_q.fault;

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: alignment, predecode cuts, backpressure ordering,
// stale/misaligned lines, flush and mid-stream reset.
module tb_fetch_align;

    localparam int LW = 8;
    localparam int OS = 10;
    localparam int XL = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JAL100 = 32'h1000_006F;
    localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;

    logic             clk;
    logic             rst;
    logic             i_flush;
    logic             i_lineValid;
    logic             o_lineReady;
    logic [XL-6:0]    i_lineAddr;
    logic [LW*32-1:0] i_lineData;
    logic [XL-1:0]    i_startPC;
    logic             o_outValid;
    logic             i_outReady;
    logic [OS*64-1:0] o_alignedInstructionTable;
    logic [3:0]       o_cutPosition;
    logic             o_bNum;
    logic [XL-1:0]    o_jumpAddr;
    logic             o_refetch;
    logic             o_fault;

    int n_checks = 0;
    int n_pass   = 0;
    logic [69:0] exp_q[$];

    fetch_align #(.LINE_WORDS(LW), .OUT_SLOTS(OS), .XLEN(XL)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_lineValid(i_lineValid),
        .o_lineReady(o_lineReady), .i_lineAddr(i_lineAddr), .i_lineData(i_lineData),
        .i_startPC(i_startPC), .o_outValid(o_outValid), .i_outReady(i_outReady),
        .o_alignedInstructionTable(o_alignedInstructionTable), .o_cutPosition(o_cutPosition),
        .o_bNum(o_bNum), .o_jumpAddr(o_jumpAddr), .o_refetch(o_refetch), .o_fault(o_fault)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] slot_insn(input int k);
        return o_alignedInstructionTable[k*64 +: 32];
    endfunction

    function automatic logic [31:0] slot_pc(input int k);
        return o_alignedInstructionTable[k*64+32 +: 32];
    endfunction

    // Packed view of a packet head: {fault, cut, bnum, jump, slot0 PC}
    function automatic logic [69:0] head_obs();
        return {o_fault, o_cutPosition, o_bNum, o_jumpAddr, slot_pc(0)};
    endfunction

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [26:0] la, input logic [31:0] pc,
                           input logic [LW*32-1:0] d, output logic acc);
        i_lineValid = 1'b1;
        i_lineAddr  = la;
        i_startPC   = pc;
        i_lineData  = d;
        acc = o_lineReady && !i_flush;
        step();
        i_lineValid = 1'b0;
    endtask

    task automatic pop();
        i_outReady = 1'b1;
        step();
        i_outReady = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [LW*32-1:0] d_nop;
    logic [LW*32-1:0] d_jal;
    logic [LW*32-1:0] d_br;
    logic             acc;
    logic             c_pending;
    int               n_out;
    int               cyc;

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_lineValid = 1'b0; i_outReady = 1'b0;
        i_lineAddr = '0; i_lineData = '0; i_startPC = '0;
        for (int w = 0; w < LW; w++) d_nop[w*32 +: 32] = NOP;
        d_jal = d_nop;
        d_jal[5*32 +: 32] = JAL100;
        d_br = d_nop;
        d_br[2*32 +: 32] = BEQ_M8;
        d_br[5*32 +: 32] = JAL100;

        do_reset();
        check("rst_valid", o_outValid, 0);
        check("rst_ready", o_lineReady, 1);
        check("rst_cut", o_cutPosition, 4'hF);
        check("rst_bnum", o_bNum, 0);
        check("rst_jump", o_jumpAddr, 0);
        check("rst_refetch", o_refetch, 0);
        check("rst_fault", o_fault, 0);
        check("rst_table", |o_alignedInstructionTable, 0);

        // Eight NOPs from PC 0x40
        present(27'd2, 32'h40, d_nop, acc);
        check("nop_acc", acc, 1);
        check("nop_valid", o_outValid, 1);
        check("nop_cut", o_cutPosition, 4'd7);
        check("nop_s0_pc", slot_pc(0), 32'h40);
        check("nop_s0_insn", slot_insn(0), NOP);
        check("nop_s7_pc", slot_pc(7), 32'h5C);
        check("nop_bnum", o_bNum, 0);
        check("nop_jump", o_jumpAddr, 0);
        check("nop_s89", |o_alignedInstructionTable[OS*64-1:LW*64], 0);
        pop();
        check("nop_popped", o_outValid, 0);

        // Offset 4, JAL +0x100 in word 5
        present(27'd2, 32'h50, d_jal, acc);
        check("jal_valid", o_outValid, 1);
        check("jal_cut", o_cutPosition, 4'd1);
        check("jal_s0_pc", slot_pc(0), 32'h50);
        check("jal_s1_pc", slot_pc(1), 32'h54);
        check("jal_s1_insn", slot_insn(1), JAL100);
        check("jal_bnum", o_bNum, 1);
        check("jal_target", o_jumpAddr, 32'h154);
        check("jal_s4", |o_alignedInstructionTable[OS*64-1:4*64], 0);
        pop();

        // Backward BEQ in word 2 wins over the later JAL
        present(27'd2, 32'h40, d_br, acc);
        check("br_cut", o_cutPosition, 4'd2);
        check("br_bnum", o_bNum, 1);
        check("br_target", o_jumpAddr, 32'h40);
        pop();

        // Backpressure: three lines back-to-back with the queue stalled
        present(27'd2, 32'h40, d_nop, acc);
        check("bp_acc_a", acc, 1);
        exp_q.push_back({1'b0, 4'd7, 1'b0, 32'h0, 32'h40});
        present(27'd2, 32'h50, d_jal, acc);
        check("bp_acc_b", acc, 1);
        exp_q.push_back({1'b0, 4'd1, 1'b1, 32'h154, 32'h50});
        check("bp_ready_low", o_lineReady, 0);
        present(27'd2, 32'h48, d_nop, acc);
        check("bp_acc_c", acc, 0);
        check("bp_ready_still_low", o_lineReady, 0);
        i_lineValid = 1'b1;
        i_outReady  = 1'b1;
        c_pending   = 1'b1;
        n_out = 0;
        cyc   = 0;
        while ((exp_q.size() > 0 || c_pending) && cyc < 20) begin
            if (o_outValid) begin
                if (exp_q.size() == 0) check("bp_extra", 1, 0);
                else check("bp_pkt", head_obs(), exp_q.pop_front());
                n_out++;
            end
            if (c_pending && o_lineReady) begin
                exp_q.push_back({1'b0, 4'd5, 1'b0, 32'h0, 32'h48});
                c_pending = 1'b0;
            end
            step();
            if (!c_pending) i_lineValid = 1'b0;
            cyc++;
        end
        i_lineValid = 1'b0;
        i_outReady  = 1'b0;
        check("bp_timeout", cyc < 20, 1);
        check("bp_count", n_out, 3);
        check("bp_drained", o_outValid, 0);

        // Stale line
        present(27'd2, 32'h84, d_nop, acc);
        check("stale_acc", acc, 1);
        check("stale_refetch", o_refetch, 1);
        check("stale_valid", o_outValid, 0);
        step();
        check("stale_refetch_end", o_refetch, 0);
        check("stale_valid_end", o_outValid, 0);

        // Misaligned PC with a matching line
        present(27'd2, 32'h42, d_nop, acc);
        check("mis_valid", o_outValid, 1);
        check("mis_cut", o_cutPosition, 4'hF);
        check("mis_fault", o_fault, 1);
        check("mis_bnum", o_bNum, 0);
        check("mis_table", |o_alignedInstructionTable, 0);
        pop();
        check("mis_fault_clear", o_fault, 0);

        // Misaligned and stale: stale wins
        present(27'd2, 32'h86, d_nop, acc);
        check("ms_refetch", o_refetch, 1);
        check("ms_valid", o_outValid, 0);
        step();

        // Flush with a full FIFO and a new line presented
        present(27'd2, 32'h40, d_nop, acc);
        present(27'd2, 32'h44, d_nop, acc);
        check("fl_full_ready", o_lineReady, 0);
        i_flush = 1'b1;
        present(27'd2, 32'h48, d_nop, acc);
        i_flush = 1'b0;
        check("fl_valid", o_outValid, 0);
        check("fl_ready", o_lineReady, 1);
        step();
        check("fl_not_enq", o_outValid, 0);

        // Flush with one entry and room: the presented line is still dropped
        present(27'd2, 32'h40, d_nop, acc);
        i_flush = 1'b1;
        present(27'd2, 32'h44, d_nop, acc);
        i_flush = 1'b0;
        check("fl1_valid", o_outValid, 0);
        step();
        check("fl1_not_enq", o_outValid, 0);

        // Reset mid-stream
        present(27'd2, 32'h40, d_nop, acc);
        present(27'd2, 32'h44, d_nop, acc);
        check("rs_full_ready", o_lineReady, 0);
        rst = 1'b1;
        present(27'd2, 32'h48, d_nop, acc);
        rst = 1'b0;
        check("rs_valid", o_outValid, 0);
        check("rs_ready", o_lineReady, 1);
        check("rs_cut", o_cutPosition, 4'hF);
        step();
        check("rs_not_enq", o_outValid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
